// File: rtl/pc_sequencer_if.sv
// Decode/control <-> next-PC sequencer bundle for the i281 program counter.
// Latency: pure wiring, no storage.
// Backpressure: none; stall/halt_req are level inputs sampled every cycle.
//
// master : decode/control side plus PC feedback (drives run, halt_req, stall,
//          branch_taken, branch_offset, step_en, step, pc_value)
// slave  : pc_sequencer (drives pc_next, pc_load, state, halted, instr_count)
interface pc_sequencer_if #(
    parameter int N     = 6,
    parameter int CNT_W = 16
);
    logic             run;
    logic             halt_req;
    logic             stall;
    logic             branch_taken;
    logic [N-1:0]     branch_offset;
    logic             step_en;
    logic             step;
    logic [N-1:0]     pc_value;
    logic [N-1:0]     pc_next;
    logic             pc_load;
    logic [1:0]       state;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output run, halt_req, stall, branch_taken, branch_offset,
               step_en, step, pc_value,
        input  pc_next, pc_load, state, halted, instr_count
    );

    modport slave (
        input  run, halt_req, stall, branch_taken, branch_offset,
               step_en, step, pc_value,
        output pc_next, pc_load, state, halted, instr_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: run/stall/halt/single-step FSM, next-value adder, retired count.
// Latency: pc_load/pc_next combinational from state and inputs; state/count update on clock.
// Backpressure: stall holds the PC (a step requested while stalled stays pending); halt is absorbing.
//
// Ports: clock, reset (synchronous, active-high), bus (pc_sequencer_if.slave).
// Optional feature macro PC_SEQ_STEP_EN: compiles in PAUSE, the pending-step
// flag and step_en/step handling. Without it step_en/step are ignored and
// run in IDLE always enters RUN.
module pc_sequencer #(
    parameter int N     = 6,
    parameter int CNT_W = 16
) (
    input  logic         clock,
    input  logic         reset,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        HALT  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic             load;
    logic [CNT_W-1:0] cnt_q;

`ifdef PC_SEQ_STEP_EN
    logic             pend_q, pend_d;
`else
    // step_en/step are part of the bundle but carry no meaning in this build.
    logic             unused_step;
    assign unused_step = bus.step_en ^ bus.step;
`endif

    // Computed every cycle regardless of load; N-bit add wraps mod 2^N and
    // the offset is already N bits wide, so sign extension is implicit.
    assign bus.pc_next = bus.pc_value + N'(1)
                       + (bus.branch_taken ? bus.branch_offset : '0);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
`ifdef PC_SEQ_STEP_EN
        pend_d  = pend_q;
`endif
        // Reset wins over everything, including the combinational load.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (bus.run) begin
`ifdef PC_SEQ_STEP_EN
                        state_d = bus.step_en ? PAUSE : RUN;
`else
                        state_d = RUN;
`endif
                    end
                end
                RUN: begin
                    if (bus.halt_req) begin
                        state_d = HALT;
                    end else if (bus.stall) begin
                        state_d = RUN;
`ifdef PC_SEQ_STEP_EN
                    end else if (bus.step_en) begin
                        state_d = PAUSE;
`endif
                    end else begin
                        load = 1'b1;
                    end
                end
`ifdef PC_SEQ_STEP_EN
                PAUSE: begin
                    if (bus.halt_req) begin
                        state_d = HALT;
                        pend_d  = 1'b0;
                    end else if (!bus.step_en) begin
                        state_d = RUN;
                        pend_d  = 1'b0;
                    end else if (bus.step || pend_q) begin
                        // Several pulses while stalled collapse into one flag.
                        if (bus.stall) begin
                            pend_d = 1'b1;
                        end else begin
                            load   = 1'b1;
                            pend_d = 1'b0;
                        end
                    end
                end
`else
                PAUSE: state_d = IDLE;
`endif
                HALT: state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef PC_SEQ_STEP_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef PC_SEQ_STEP_EN
            pend_q  <= pend_d;
`endif
            if (load && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_load     = load;
    assign bus.state       = state_q;
    assign bus.halted      = (state_q == HALT);
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic against a rule model.
// Latency: model predicts same-cycle pc_load/pc_next and next-cycle state/count/pc.
// Backpressure: stall/halt driven directly from stimulus.
module tb_pc_sequencer;

    localparam int N     = 6;
    localparam int CNT_W = 16;
    localparam int PCMOD = 1 << N;
    localparam int CMAX  = (1 << CNT_W) - 1;

`ifdef PC_SEQ_STEP_EN
    localparam bit STEP_BUILT = 1'b1;
`else
    localparam bit STEP_BUILT = 1'b0;
`endif

    // Model state names as plain integers matching the published encoding.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_HALT = 3;

    logic clk;
    logic reset;
    logic [N-1:0] pc_reg;

    int n_checks = 0;
    int n_pass   = 0;

    pc_sequencer_if #(.N(N), .CNT_W(CNT_W)) bus ();

    pc_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The program counter register itself, cleared by the same reset.
    always @(posedge clk) begin
        if (reset)            pc_reg <= '0;
        else if (bus.pc_load) pc_reg <= bus.pc_next;
    end
    assign bus.pc_value = pc_reg;

    // Reference model: values describe the block after the next rising edge.
    int m_st   = M_IDLE;
    bit m_pend = 1'b0;
    int m_cnt  = 0;
    int m_pc   = 0;

    always @(negedge clk) begin
        int  off_i;
        int  e_next;
        bit  adv;
        int  nst;
        bit  npend;
        off_i  = bus.branch_offset >= (PCMOD / 2) ? int'(bus.branch_offset) - PCMOD
                                                   : int'(bus.branch_offset);
        e_next = (((m_pc + 1 + (bus.branch_taken ? off_i : 0)) % PCMOD) + PCMOD) % PCMOD;
        adv = !reset && (
                (m_st == M_RUN && !bus.halt_req && !bus.stall && !(STEP_BUILT && bus.step_en)) ||
                (m_st == M_PAUSE && !bus.halt_req && bus.step_en && (bus.step || m_pend) && !bus.stall));

        n_checks++;
        if (bus.pc_load !== adv) $display("FAIL pc_load t=%0t got=%b want=%b", $time, bus.pc_load, adv);
        else n_pass++;
        n_checks++;
        if (bus.pc_next !== e_next[N-1:0]) $display("FAIL pc_next t=%0t got=%0d want=%0d", $time, bus.pc_next, e_next);
        else n_pass++;
        n_checks++;
        if (bus.state !== m_st[1:0]) $display("FAIL state t=%0t got=%0d want=%0d", $time, bus.state, m_st);
        else n_pass++;
        n_checks++;
        if (bus.halted !== (m_st == M_HALT)) $display("FAIL halted t=%0t got=%b want=%b", $time, bus.halted, m_st == M_HALT);
        else n_pass++;
        n_checks++;
        if (bus.instr_count !== m_cnt[CNT_W-1:0]) $display("FAIL instr_count t=%0t got=%0d want=%0d", $time, bus.instr_count, m_cnt);
        else n_pass++;
        n_checks++;
        if (bus.pc_value !== m_pc[N-1:0]) $display("FAIL pc_value t=%0t got=%0d want=%0d", $time, bus.pc_value, m_pc);
        else n_pass++;

        nst   = m_st;
        npend = m_pend;
        if (reset) begin
            nst = M_IDLE; npend = 1'b0;
            m_cnt <= 0;
            m_pc  <= 0;
        end else begin
            if (adv) begin
                m_pc <= e_next;
                if (m_cnt < CMAX) m_cnt <= m_cnt + 1;
            end
            if (m_st == M_IDLE && bus.run)
                nst = (STEP_BUILT && bus.step_en) ? M_PAUSE : M_RUN;
            else if (m_st == M_RUN && bus.halt_req)
                nst = M_HALT;
            else if (m_st == M_RUN && !bus.stall && STEP_BUILT && bus.step_en)
                nst = M_PAUSE;
            else if (m_st == M_PAUSE) begin
                if (bus.halt_req)      begin nst = M_HALT; npend = 1'b0; end
                else if (!bus.step_en) begin nst = M_RUN;  npend = 1'b0; end
                else if (bus.step || m_pend) npend = bus.stall;
            end
        end
        m_st   <= nst;
        m_pend <= npend;
    end

    task automatic idle_inputs();
        bus.run = 0; bus.halt_req = 0; bus.stall = 0; bus.branch_taken = 0;
        bus.branch_offset = '0; bus.step_en = 0; bus.step = 0;
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1; tick(); reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs(); tick(2); reset = 0;
        n_checks++;
        if (bus.state !== 2'b00) $display("FAIL reset_state got=%0d want=0", bus.state); else n_pass++;
        n_checks++;
        if (bus.pc_load !== 1'b0 || bus.halted !== 1'b0) $display("FAIL reset_outputs got load=%b halted=%b want 0/0", bus.pc_load, bus.halted); else n_pass++;
        n_checks++;
        if (bus.instr_count !== '0 || bus.pc_value !== '0) $display("FAIL reset_count_pc got cnt=%0d pc=%0d want 0/0", bus.instr_count, bus.pc_value); else n_pass++;
    endtask

    task automatic test_sequential();
        do_reset();
        bus.run = 1; tick(); bus.run = 0;
        n_checks++;
        if (bus.pc_value !== 6'd0 || bus.state !== 2'b01) $display("FAIL run_entry got pc=%0d state=%0d want 0/1", bus.pc_value, bus.state); else n_pass++;
        tick(64);
        n_checks++;
        if (bus.pc_value !== 6'd0) $display("FAIL wrap got pc=%0d want 0", bus.pc_value); else n_pass++;
        tick(6);
        n_checks++;
        if (bus.instr_count !== 16'd70 || bus.state !== 2'b01 || bus.pc_value !== 6'd6)
            $display("FAIL seq70 got cnt=%0d state=%0d pc=%0d want 70/1/6", bus.instr_count, bus.state, bus.pc_value);
        else n_pass++;
    endtask

    task automatic test_branch();
        do_reset();
        bus.run = 1; tick(); bus.run = 0;
        tick(10);
        bus.branch_taken = 1; bus.branch_offset = 6'b111100; tick();
        n_checks++;
        if (bus.pc_value !== 6'd7) $display("FAIL branch_back got=%0d want=7", bus.pc_value); else n_pass++;
        bus.branch_offset = 6'd5; tick();
        n_checks++;
        if (bus.pc_value !== 6'd13) $display("FAIL branch_fwd got=%0d want=13", bus.pc_value); else n_pass++;
        idle_inputs();
        do_reset();
        bus.run = 1; tick(); bus.run = 0;
        bus.branch_taken = 1; bus.branch_offset = 6'h3f; tick();
        n_checks++;
        if (bus.pc_value !== 6'd0 || bus.instr_count !== 16'd1) $display("FAIL branch_m1_at0 got pc=%0d cnt=%0d want 0/1", bus.pc_value, bus.instr_count); else n_pass++;
        bus.branch_offset = 6'd1; tick();
        bus.branch_offset = 6'b111100; tick();
        n_checks++;
        if (bus.pc_value !== 6'd63) $display("FAIL branch_m4_at2 got pc=%0d want 63", bus.pc_value); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_stall_halt();
        do_reset();
        bus.run = 1; tick(); bus.run = 0;
        tick(5);
        bus.stall = 1; tick(3);
        n_checks++;
        if (bus.pc_value !== 6'd5 || bus.instr_count !== 16'd5) $display("FAIL stall_hold got pc=%0d cnt=%0d want 5/5", bus.pc_value, bus.instr_count); else n_pass++;
        bus.halt_req = 1; tick();
        bus.halt_req = 0; bus.stall = 0;
        n_checks++;
        if (bus.state !== 2'b11 || bus.halted !== 1'b1 || bus.pc_value !== 6'd5) $display("FAIL halt_entry got state=%0d halted=%b pc=%0d want 3/1/5", bus.state, bus.halted, bus.pc_value); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            bus.run = 1; bus.step_en = 1'($urandom); bus.step = 1'($urandom); tick();
        end
        idle_inputs();
        n_checks++;
        if (bus.state !== 2'b11 || bus.instr_count !== 16'd5) $display("FAIL halt_absorb got state=%0d cnt=%0d want 3/5", bus.state, bus.instr_count); else n_pass++;
        do_reset();
        n_checks++;
        if (bus.state !== 2'b00 || bus.pc_value !== 6'd0) $display("FAIL halt_reset got state=%0d pc=%0d want 0/0", bus.state, bus.pc_value); else n_pass++;
    endtask

    task automatic test_single_step();
        do_reset();
        bus.step_en = 1; bus.run = 1; tick(); bus.run = 0;
        n_checks++;
        if (bus.state !== (STEP_BUILT ? 2'b10 : 2'b01)) $display("FAIL step_entry got state=%0d want=%0d", bus.state, STEP_BUILT ? 2 : 1); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            bus.step = 1; tick(); bus.step = 0; tick();
        end
        n_checks++;
        if (bus.pc_value !== (STEP_BUILT ? 6'd3 : 6'd6)) $display("FAIL step_three got pc=%0d want=%0d", bus.pc_value, STEP_BUILT ? 3 : 6); else n_pass++;
        bus.stall = 1; bus.step = 1; tick();
        bus.step = 0; tick();
        bus.step = 1; tick(2);
        bus.step = 0;
        n_checks++;
        if (bus.pc_value !== (STEP_BUILT ? 6'd3 : 6'd6)) $display("FAIL step_stalled got pc=%0d want=%0d", bus.pc_value, STEP_BUILT ? 3 : 6); else n_pass++;
        bus.stall = 0; tick();
        n_checks++;
        if (bus.pc_value !== (STEP_BUILT ? 6'd4 : 6'd7)) $display("FAIL step_release got pc=%0d want=%0d", bus.pc_value, STEP_BUILT ? 4 : 7); else n_pass++;
        tick();
        n_checks++;
        if (bus.pc_value !== (STEP_BUILT ? 6'd4 : 6'd8)) $display("FAIL step_once got pc=%0d want=%0d", bus.pc_value, STEP_BUILT ? 4 : 8); else n_pass++;
        bus.step_en = 0; tick();
        n_checks++;
        if (bus.state !== 2'b01 || bus.pc_value !== (STEP_BUILT ? 6'd4 : 6'd9)) $display("FAIL step_resume got state=%0d pc=%0d want 1/%0d", bus.state, bus.pc_value, STEP_BUILT ? 4 : 9); else n_pass++;
        tick();
        n_checks++;
        if (bus.pc_value !== (STEP_BUILT ? 6'd5 : 6'd10)) $display("FAIL step_run got pc=%0d want=%0d", bus.pc_value, STEP_BUILT ? 5 : 10); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.step_en = 1; bus.run = 1; tick(); bus.run = 0;
        bus.stall = 1; bus.step = 1; tick();
        reset = 1; tick(); reset = 0; idle_inputs();
        n_checks++;
        if (bus.state !== 2'b00 || bus.pc_value !== 6'd0 || bus.instr_count !== '0 || bus.pc_load !== 1'b0)
            $display("FAIL reset_pending got state=%0d pc=%0d cnt=%0d load=%b want 0/0/0/0", bus.state, bus.pc_value, bus.instr_count, bus.pc_load);
        else n_pass++;
        bus.run = 1; tick(); bus.run = 0;
        tick(40);
        n_checks++;
        if (bus.pc_value !== 6'd40) $display("FAIL run_to_40 got pc=%0d want 40", bus.pc_value); else n_pass++;
        reset = 1; tick(); reset = 0;
        n_checks++;
        if (bus.state !== 2'b00 || bus.pc_value !== 6'd0 || bus.instr_count !== '0 || bus.pc_load !== 1'b0)
            $display("FAIL reset_run got state=%0d pc=%0d cnt=%0d load=%b want 0/0/0/0", bus.state, bus.pc_value, bus.instr_count, bus.pc_load);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            reset             = ($urandom_range(0, 49) == 0);
            bus.run           = ($urandom_range(0, 3) == 0);
            bus.halt_req      = ($urandom_range(0, 39) == 0);
            bus.stall         = ($urandom_range(0, 3) == 0);
            bus.branch_taken  = 1'($urandom);
            bus.branch_offset = 6'($urandom);
            if ($urandom_range(0, 7) == 0) bus.step_en = ~bus.step_en;
            bus.step          = ($urandom_range(0, 2) == 0);
            tick();
        end
        reset = 0; idle_inputs();
        tick();
        n_checks++;
        if (bus.instr_count !== m_cnt[CNT_W-1:0] || bus.pc_value !== m_pc[N-1:0])
            $display("FAIL random_final got cnt=%0d pc=%0d want %0d/%0d", bus.instr_count, bus.pc_value, m_cnt, m_pc);
        else n_pass++;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_stall_halt();
        test_single_step();
        test_reset_mid();
        test_random();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
